i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this target answers to.
REQ-002 SHALL have clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have scl  input  1  I2C clock from the bus master; this block never drives it.
REQ-005 SHALL have sda  inout  1  open-drain data: driven 0 when pulling low, otherwise 1'bz.
REQ-006 SHALL have tx_data  input  8  byte returned on a read; sampled when tx_req pulses.
REQ-007 SHALL have rx_data  output  8  last byte received in a write transaction.
REQ-008 SHALL have rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-009 SHALL have tx_req  output  1  one-clk pulse when tx_data is loaded.
REQ-010 SHALL have busy  output  1  high from an addressed START/repeated START to STOP or NACK-abort.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers and derive rise/fall strobes from the last two synchronized samples (detection latency 3 clk).
REQ-012 SHALL detect START as a synchronized sda fall while synchronized scl is high, and STOP as an sda rise while scl is high.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-014 START in any state SHALL enter ADDR with bit counter 7 and sda released (repeated START supported).
REQ-015 STOP in any state SHALL enter IDLE, release sda and deassert busy on the following clk.
REQ-016 In ADDR and WR_DATA, sda SHALL be sampled MSB-first on each scl rise into a shift register.
REQ-017 After the 8th address bit, on the next scl fall: if addr[7:1]==SLAVE_ADDR, SHALL drive sda low, set busy, enter ADDR_ACK; otherwise SHALL release sda and enter IDLE, ignoring the bus until the next START.
REQ-018 On the scl fall ending ADDR_ACK: R/W=0 SHALL release sda and enter WR_DATA; R/W=1 SHALL pulse tx_req, load tx_data, drive bit 7, enter RD_DATA.
REQ-019 After the 8th WR_DATA bit, on the next scl fall SHALL update rx_data, pulse rx_valid for exactly 1 clk, drive sda low, enter WR_ACK; the scl fall ending WR_ACK SHALL release sda and return to WR_DATA with counter 7.
REQ-020 In RD_DATA, each scl fall SHALL present the next bit (0 drives low, 1 releases); after bit 0's scl fall SHALL release sda and enter RD_ACK.
REQ-021 In RD_ACK, sda sampled 0 on scl rise (ACK) SHALL, on the next scl fall, pulse tx_req, load tx_data and continue RD_DATA; sampled 1 (NACK) SHALL enter IDLE with sda released, busy staying high until STOP.
REQ-022 sda SHALL change only on a detected scl fall, never while scl is high, except release on STOP/reset.
REQ-023 A START or STOP arriving mid-byte SHALL discard the partial byte with no rx_valid pulse.

Reset
REQ-024 On rst, outputs SHALL be: sda released (1'bz), rx_data 8'h00, rx_valid 0, tx_req 0, busy 0; state IDLE, synchronizers 1'b1.
REQ-025 Reset asserted mid-transaction SHALL release sda immediately (asynchronously), and after release the block SHALL wait for a fresh START.

Configuration
REQ-026 With macro I2C_SLAVE_GCALL_EN defined, address byte 8'h00 (general call, write) SHALL also be ACKed and handled as a write; without it, 8'h00 SHALL be NACKed unless SLAVE_ADDR==0, and no general-call logic SHALL be synthesized.

Verification
REQ-027 START, 0xA0, 0x3C, STOP -> ACK on both bytes; rx_data=8'h3C; one rx_valid pulse; busy 0 after STOP.
REQ-028 START, 0xA1, tx_data=8'h96, master NACK, STOP -> 1 tx_req pulse; bits 1,0,0,1,0,1,1,0 on sda; sda released in RD_ACK.
REQ-029 START, 0xA1, ACK, ACK, NACK with tx_data 8'h11, 8'h22, 8'h33 -> 3 tx_req pulses, bytes 11/22/33 on sda.
REQ-030 START, 0xB0 (addr 7'h58) -> no ACK (sda high at 9th scl), busy 0, no rx_valid.
REQ-031 START, 0xA0, 4 data bits, repeated START, 0xA1 -> no rx_valid; read proceeds with tx_req pulse.
REQ-032 rst asserted during WR_ACK with sda low -> sda 1'bz same cycle; all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target supporting byte writes, byte reads and
// repeated START. Define I2C_SLAVE_GCALL_EN to also acknowledge the general
// call address byte 8'h00 and treat it as a write.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  // [0] first sync flop, [1] synchronized sample, [2] previous synchronized sample
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  state_t     state_q;
  logic [3:0] bit_cnt_q;   // 7..0 counts bits; 4'hF marks a completed byte
  logic [7:0] shift_q;
  logic       rw_q;
  logic       ack_q;       // master ACK seen on the RD_ACK rising edge
  logic       sda_oe_q;    // 1 pulls sda low
  logic       busy_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;

  logic scl_rise_d, scl_fall_d, sda_rise_d, sda_fall_d;
  logic start_d, stop_d, addr_hit_d;

  assign scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_rise_d = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall_d = ~sda_sync_q[1] & sda_sync_q[2];
  assign start_d    = sda_fall_d & scl_sync_q[1];
  assign stop_d     = sda_rise_d & scl_sync_q[1];

`ifdef I2C_SLAVE_GCALL_EN
  assign addr_hit_d = (shift_q[7:1] == SLAVE_ADDR) || (shift_q == 8'h00);
`else
  assign addr_hit_d = (shift_q[7:1] == SLAVE_ADDR);
`endif

  // Open-drain output; the async reset on sda_oe_q releases the line at once.
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

  // Bring scl/sda into the clk domain and keep one extra sample for edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl};
      sda_sync_q <= {sda_sync_q[1:0], sda};
    end
  end

  // Protocol state machine; sda only moves on a detected scl fall (or STOP/START).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd7;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop_d) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_d) begin
        // Partial bytes are simply dropped: the counter restarts at 7.
        state_q   <= ADDR;
        bit_cnt_q <= 4'd7;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          ADDR, WR_DATA: begin
            if (scl_rise_d && (bit_cnt_q != 4'hF)) begin
              shift_q   <= {shift_q[6:0], sda_sync_q[1]};
              bit_cnt_q <= bit_cnt_q - 4'd1;
            end else if (scl_fall_d && (bit_cnt_q == 4'hF)) begin
              if (state_q == ADDR) begin
                if (addr_hit_d) begin
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rw_q     <= shift_q[0];
                  state_q  <= ADDR_ACK;
                end else begin
                  sda_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
                end
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                sda_oe_q   <= 1'b1;
                state_q    <= WR_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_d) begin
              if (rw_q) begin
                tx_req_q  <= 1'b1;
                shift_q   <= tx_data;
                sda_oe_q  <= ~tx_data[7];
                bit_cnt_q <= 4'd6;
                state_q   <= RD_DATA;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd7;
                state_q   <= WR_DATA;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall_d) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 4'd7;
              state_q   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall_d) begin
              if (bit_cnt_q == 4'hF) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q  <= ~shift_q[bit_cnt_q[2:0]];
                bit_cnt_q <= bit_cnt_q - 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise_d) begin
              ack_q <= ~sda_sync_q[1];
            end else if (scl_fall_d) begin
              if (ack_q) begin
                tx_req_q  <= 1'b1;
                shift_q   <= tx_data;
                sda_oe_q  <= ~tx_data[7];
                bit_cnt_q <= 4'd6;
                state_q   <= RD_DATA;
              end else begin
                // Master NACK: stay busy until the STOP arrives.
                sda_oe_q <= 1'b0;
                state_q  <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
